bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble binary-to-BCD converter; upstream feeder of the hex_display

---
 rtl/bin_to_bcd_seq.sv | 141 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Optional build macro LEADING_ZERO_BLANK_EN registers a leading-zero blank mask on blank.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start; bcd_out holds the last result
// ST_SHIFT | one add-3/shift step per edge, BIN_W steps in total
// ST_DONE  | one-cycle result-valid state, done pulse is high here
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [BIN_W-1:0]     shreg, shreg_nxt;
    logic [4*DIGITS-1:0]  scratch, scratch_nxt;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 load, shift_en, finish;
    logic [3:0]           nib_adj;
    logic                 carry;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = 1'b1;
                if (count == CNT_W'(1)) begin
                    finish    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Nibbles are adjusted in parallel; each adjusted nibble's MSB carries into the next one up.
    always_comb begin
        scratch_nxt = '0;
        nib_adj     = '0;
        carry       = shreg[BIN_W-1];
        for (int i = 0; i < DIGITS; i++) begin
            nib_adj = scratch[4*i +: 4];
            if (nib_adj >= 4'd5) begin
                nib_adj = nib_adj + 4'd3;
            end
            scratch_nxt[4*i +: 4] = {nib_adj[2:0], carry};
            carry = nib_adj[3];
        end
        shreg_nxt = {shreg[BIN_W-2:0], 1'b0};
        count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            scratch <= '0;
            count   <= '0;
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                shreg   <= bin_in;
                scratch <= '0;
                count   <= CNT_W'(BIN_W);
            end else if (shift_en) begin
                shreg   <= shreg_nxt;
                scratch <= scratch_nxt;
                count   <= count_nxt;
            end
            if (finish) begin
                bcd_out <= scratch_nxt;
            end
        end
    end

    assign busy = (state == ST_SHIFT) || (state == ST_DONE);

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_reg, blank_nxt;
    logic              upper_zero;

    // Scan from the top digit down; digit 0 is never blanked so zero still shows "0".
    always_comb begin
        blank_nxt  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero && (scratch_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = upper_zero;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blank_reg <= '0;
        end else if (finish) begin
            blank_reg <= blank_nxt;
        end
    end

    assign blank = blank_reg;
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized self-checking bench for bin_to_bcd_seq against a decimal-arithmetic model.
// Blank expectations follow LEADING_ZERO_BLANK_EN when it is defined for the build.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = BIN_W;   // edges from accepting edge to done visible

    logic                 clock;
    logic                 reset;
    logic                 start;
    logic [BIN_W-1:0]     bin_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [DIGITS-1:0]    blank;

    int n_checks = 0;
    int n_errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .blank   (blank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned         x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Digit i and everything above it are zero exactly when v < 10**i.
    function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
        logic [DIGITS-1:0] b;
        int unsigned       p;
        b = '0;
`ifdef LEADING_ZERO_BLANK_EN
        p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
`else
        p = 0;
`endif
        return b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_conv(input int unsigned v, input string tag);
        int n;
        start  = 1'b1;
        bin_in = BIN_W'(v);
        tick();
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        check({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        n = 1;
        tick();
        while (!done && n < 3 * LAT) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(LAT));
        check({tag, " bcd_out"}, 32'(bcd_out), 32'(ref_bcd(v)));
        check({tag, " blank"}, 32'(blank), 32'(ref_blank(v)));
        tick();
        check({tag, " done_falls"}, 32'(done), 32'd0);
        check({tag, " idle_not_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          t_first, t_second;
        logic [31:0] held;
        logic        stable_ok;
        int unsigned v;

        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset bcd_out", 32'(bcd_out), 32'd0);
        check("reset blank", 32'(blank), 32'd0);

        run_conv(0, "zero");
        run_conv(65535, "max");
        run_conv(1234, "v1234");

        // Start pulses mid-conversion must be ignored.
        start  = 1'b1;
        bin_in = BIN_W'(9);
        tick();
        start  = 1'b0;
        pulses = 0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 3 || c == 16) begin
                start  = 1'b1;
                bin_in = BIN_W'(42);
            end else begin
                start  = 1'b0;
            end
            tick();
            if (done) pulses++;
        end
        start = 1'b0;
        check("ignore_start pulses", 32'(pulses), 32'd1);
        check("ignore_start bcd_out", 32'(bcd_out), 32'(ref_bcd(9)));

        // Reset mid-conversion aborts without a done pulse.
        start  = 1'b1;
        bin_in = BIN_W'(999);
        tick();
        start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort bcd_out", 32'(bcd_out), 32'd0);
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (done) pulses++;
        end
        check("abort no_done", 32'(pulses), 32'd0);
        run_conv(7, "after_abort");

        // Back-to-back with start held high.
        start  = 1'b1;
        bin_in = BIN_W'(100);
        tick();
        bin_in    = BIN_W'(250);
        pulses    = 0;
        t_first   = 0;
        t_second  = 0;
        held      = '0;
        stable_ok = 1'b1;
        for (int c = 1; c <= 60 && pulses < 2; c++) begin
            tick();
            if (done) begin
                pulses++;
                if (pulses == 1) begin
                    t_first = c;
                    held    = 32'(bcd_out);
                    check("b2b first bcd_out", 32'(bcd_out), 32'(ref_bcd(100)));
                end else begin
                    t_second = c;
                    check("b2b second bcd_out", 32'(bcd_out), 32'(ref_bcd(250)));
                end
            end else if (pulses == 1 && 32'(bcd_out) != held) begin
                stable_ok = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b pulses", 32'(pulses), 32'd2);
        check("b2b spacing", 32'(t_second - t_first), 32'(LAT + 2));
        check("b2b stable", 32'(stable_ok), 32'd1);
        tick();
        tick();

        for (int r = 0; r < 24; r++) begin
            v = $urandom_range(0, 65535);
            if (r % 6 == 0) v = $urandom_range(0, 99);
            run_conv(v, $sformatf("rand%0d_%0d", r, v));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
